// File: rtl/stream_demux_if.sv
// rtl/stream_demux_if.sv - handshake bundle between upstream source, stream_demux and its channels
interface stream_demux_if #(
   parameter int DW   = 8,
   parameter int N_CH = 8,
   parameter int SW   = 3
);
   logic            in_valid;
   logic [DW-1:0]   in_data;
   logic [SW-1:0]   in_sel;
   logic            in_ready;
   logic [N_CH-1:0] out_valid;
   logic [DW-1:0]   out_data;
   logic [N_CH-1:0] out_ready;
   logic            drop;

   // Source side: offers words upstream and consumes the per-channel outputs
   modport master (
      output in_valid, in_data, in_sel, out_ready,
      input  in_ready, out_valid, out_data, drop
   );

   // Demux side
   modport slave (
      input  in_valid, in_data, in_sel, out_ready,
      output in_ready, out_valid, out_data, drop
   );
endinterface

// File: rtl/stream_demux.sv
// rtl/stream_demux.sv - one-stage registered stream demultiplexer; define STREAM_DEMUX_CNT_EN for per-channel transfer counters
module stream_demux #(
   parameter int DW   = 8,
   parameter int N_CH = 8,
   parameter int SW   = 3
) (
   input  logic          clk,
   input  logic          rst,
   stream_demux_if.slave bus
`ifdef STREAM_DEMUX_CNT_EN
   ,
   input  logic [SW-1:0] cnt_sel,
   output logic [15:0]   cnt_out
`endif
);

   // Every value in_sel/ch_q can encode, so ch_q may index a widened ready vector
   localparam int          NS     = 1 << SW;
   localparam logic [SW:0] N_CH_W = (SW + 1)'(N_CH);

   logic          full_q, full_d;
   logic [DW-1:0] data_q, data_d;
   logic [SW-1:0] ch_q,   ch_d;
   logic          drop_q, drop_d;

   logic [NS-1:0] rdy_ext;
   logic          sel_ok;
   logic          xfer_in;
   logic          xfer_out;

   // Zero-extend out_ready so unused encodings read as not-ready
   always_comb begin
      rdy_ext             = '0;
      rdy_ext[N_CH-1:0]   = bus.out_ready;
   end

   // Only the held channel's ready matters; others are ignored
   assign sel_ok       = {1'b0, bus.in_sel} < N_CH_W;
   assign xfer_out     = full_q & rdy_ext[ch_q];
   assign bus.in_ready = ~full_q | rdy_ext[ch_q];
   assign xfer_in      = bus.in_valid & bus.in_ready;

   // Stage next-state: empty on transfer out, reload on a good word, flag bad selects
   always_comb begin
      full_d = full_q;
      data_d = data_q;
      ch_d   = ch_q;
      drop_d = 1'b0;
      if (xfer_out) begin
         full_d = 1'b0;
      end
      if (xfer_in) begin
         if (sel_ok) begin
            full_d = 1'b1;
            data_d = bus.in_data;
            ch_d   = bus.in_sel;
         end else begin
            drop_d = 1'b1;
         end
      end
   end

   // Stage registers; reset discards any held word
   always_ff @(posedge clk) begin
      if (rst) begin
         full_q <= 1'b0;
         data_q <= '0;
         ch_q   <= '0;
         drop_q <= 1'b0;
      end else begin
         full_q <= full_d;
         data_q <= data_d;
         ch_q   <= ch_d;
         drop_q <= drop_d;
      end
   end

   // One-hot valid on the held channel, all-zero when empty
   always_comb begin
      bus.out_valid = '0;
      for (int k = 0; k < N_CH; k++) begin
         bus.out_valid[k] = full_q && (ch_q == SW'(k));
      end
   end

   assign bus.out_data = data_q;
   assign bus.drop     = drop_q;

`ifdef STREAM_DEMUX_CNT_EN
   logic [15:0] cnt_q [N_CH];
   logic [15:0] cnt_d [N_CH];
   logic [15:0] cnt_pick;
   logic [15:0] cnt_out_q, cnt_out_d;

   // Bump the counter of the channel that completes a transfer out; wraps naturally
   always_comb begin
      for (int k = 0; k < N_CH; k++) begin
         cnt_d[k] = cnt_q[k];
         if (xfer_out && (ch_q == SW'(k))) begin
            cnt_d[k] = cnt_q[k] + 16'd1;
         end
      end
   end

   // Per-channel counter registers
   always_ff @(posedge clk) begin
      for (int k = 0; k < N_CH; k++) begin
         if (rst) begin
            cnt_q[k] <= '0;
         end else begin
            cnt_q[k] <= cnt_d[k];
         end
      end
   end

   // Read mux; selects beyond the channel count read zero
   always_comb begin
      cnt_pick = '0;
      for (int k = 0; k < N_CH; k++) begin
         if (cnt_sel == SW'(k)) begin
            cnt_pick = cnt_q[k];
         end
      end
      cnt_out_d = cnt_pick;
   end

   // Registered readback, one cycle behind cnt_sel
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_out_q <= '0;
      end else begin
         cnt_out_q <= cnt_out_d;
      end
   end

   assign cnt_out = cnt_out_q;
`endif

endmodule

// File: tb/tb_stream_demux.sv
// tb/tb_stream_demux.sv - scoreboard bench for stream_demux
module tb_stream_demux;
   localparam int DW = 8;
   localparam int SW = 3;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   stream_demux_if #(.DW(DW), .N_CH(8), .SW(SW)) if8 ();
   stream_demux_if #(.DW(DW), .N_CH(6), .SW(SW)) if6 ();

`ifdef STREAM_DEMUX_CNT_EN
   logic [SW-1:0] cnt_sel8, cnt_sel6;
   logic [15:0]   cnt_out8, cnt_out6;
`endif

   stream_demux #(.DW(DW), .N_CH(8), .SW(SW)) dut8 (
      .clk (clk),
      .rst (rst),
      .bus (if8)
`ifdef STREAM_DEMUX_CNT_EN
      ,
      .cnt_sel (cnt_sel8),
      .cnt_out (cnt_out8)
`endif
   );

   stream_demux #(.DW(DW), .N_CH(6), .SW(SW)) dut6 (
      .clk (clk),
      .rst (rst),
      .bus (if6)
`ifdef STREAM_DEMUX_CNT_EN
      ,
      .cnt_sel (cnt_sel6),
      .cnt_out (cnt_out6)
`endif
   );

   typedef struct packed {
      logic [2:0] ch;
      logic [7:0] data;
   } exp_t;

   exp_t sbq[$];
   int   errors = 0;
   int   checks = 0;
   int   out_xfers = 0;
   int   xfer_mark;

   function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endfunction

   function automatic void push_exp(logic [2:0] ch, logic [7:0] d);
      exp_t e;
      e.ch   = ch;
      e.data = d;
      sbq.push_back(e);
   endfunction

   // Monitor: every transfer out on dut8 pops one expected word
   logic [7:0] mon_hs;
   int         mon_ch;
   exp_t       mon_e;
   always @(negedge clk) begin
      if (!rst) begin
         mon_hs = if8.out_valid & if8.out_ready;
         if (mon_hs != '0) begin
            out_xfers++;
            check("out_onehot", $countones(if8.out_valid), 1);
            check("sb_has_entry", 32'(sbq.size() != 0), 1);
            if (sbq.size() != 0) begin
               mon_e  = sbq.pop_front();
               mon_ch = 0;
               for (int k = 0; k < 8; k++) if (mon_hs[k]) mon_ch = k;
               check("out_ch", mon_ch, mon_e.ch);
               check("out_data", if8.out_data, mon_e.data);
            end
         end
      end
   end

   task automatic cycles(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic send8(input logic [2:0] sel, input logic [7:0] d);
      if8.in_valid = 1'b1;
      if8.in_sel   = sel;
      if8.in_data  = d;
      @(negedge clk);
      check("send_in_ready", if8.in_ready, 1);
      push_exp(sel, d);
      @(posedge clk);
      #1;
      if8.in_valid = 1'b0;
   endtask

   task automatic send6(input logic [2:0] sel, input logic [7:0] d);
      if6.in_valid = 1'b1;
      if6.in_sel   = sel;
      if6.in_data  = d;
      @(negedge clk);
      check("send6_in_ready", if6.in_ready, 1);
      @(posedge clk);
      #1;
      if6.in_valid = 1'b0;
   endtask

   initial begin
      #10_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      if8.in_valid = 1'b0; if8.in_data = '0; if8.in_sel = '0; if8.out_ready = '0;
      if6.in_valid = 1'b0; if6.in_data = '0; if6.in_sel = '0; if6.out_ready = '0;
`ifdef STREAM_DEMUX_CNT_EN
      cnt_sel8 = '0;
      cnt_sel6 = 3'd7;
`endif
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;

      // Reset state
      @(negedge clk);
      check("rst_in_ready", if8.in_ready, 1);
      check("rst_out_valid", if8.out_valid, 0);
      check("rst_drop", if8.drop, 0);
      check("rst_out_data", if8.out_data, 0);
      check("rst6_in_ready", if6.in_ready, 1);
      check("rst6_out_valid", if6.out_valid, 0);
      @(posedge clk);
      #1;

      // Sweep all channels back to back
      if8.out_ready = 8'hFF;
      xfer_mark = out_xfers;
      for (int s = 0; s < 8; s++) send8(s[2:0], 8'hA5);
      cycles(3);
      check("sweep_xfers", out_xfers - xfer_mark, 8);
      check("sweep_idle", if8.out_valid, 0);

      // Backpressure on channel 3
      if8.out_ready = 8'hF7;
      xfer_mark = out_xfers;
      send8(3'd3, 8'h5C);
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         check("bp_out_valid", if8.out_valid, 8'h08);
         check("bp_out_data", if8.out_data, 8'h5C);
         check("bp_in_ready", if8.in_ready, 0);
         @(posedge clk);
         #1;
      end
      check("bp_no_xfer", out_xfers - xfer_mark, 0);
      if8.out_ready = 8'hFF;
      cycles(3);
      check("bp_one_xfer", out_xfers - xfer_mark, 1);
      check("bp_empty", if8.out_valid, 0);

      // Foreign ready must not consume channel 2
      if8.out_ready = 8'hFB;
      xfer_mark = out_xfers;
      send8(3'd2, 8'h3C);
      cycles(3);
      @(negedge clk);
      check("foreign_out_valid", if8.out_valid, 8'h04);
      check("foreign_in_ready", if8.in_ready, 0);
      check("foreign_no_xfer", out_xfers - xfer_mark, 0);
      @(posedge clk);
      #1;
      if8.out_ready = 8'hFF;
      cycles(3);
      check("foreign_drain", out_xfers - xfer_mark, 1);

`ifdef STREAM_DEMUX_CNT_EN
      cnt_sel8 = 3'd3;
      cycles(2);
      @(negedge clk);
      check("cnt_ch3", cnt_out8, 2);
      check("cnt6_oob", cnt_out6, 0);
      @(posedge clk);
      #1;
`endif

      // Invalid selects on the 6-channel instance
      if6.out_ready = 6'h3F;
      send6(3'd7, 8'hEE);
      @(negedge clk);
      check("drop7_pulse", if6.drop, 1);
      check("drop7_out_valid", if6.out_valid, 0);
      @(posedge clk);
      #1;
      @(negedge clk);
      check("drop7_end", if6.drop, 0);
      check("drop7_still_empty", if6.out_valid, 0);
      @(posedge clk);
      #1;
      send6(3'd6, 8'hDD);
      @(negedge clk);
      check("drop6_pulse", if6.drop, 1);
      check("drop6_out_valid", if6.out_valid, 0);
      @(posedge clk);
      #1;

      // Transfer out together with an invalid-select transfer in
      if6.out_ready = 6'h3B;
      send6(3'd2, 8'h11);
      @(negedge clk);
      check("mix_held", if6.out_valid, 6'h04);
      check("mix_blocked", if6.in_ready, 0);
      @(posedge clk);
      #1;
      if6.out_ready = 6'h3F;
      send6(3'd7, 8'h99);
      @(negedge clk);
      check("mix_emptied", if6.out_valid, 0);
      check("mix_drop", if6.drop, 1);
      check("mix_data_kept", if6.out_data, 8'h11);
      @(posedge clk);
      #1;

      // Reset while channel 5 holds a word
`ifdef STREAM_DEMUX_CNT_EN
      cnt_sel8 = 3'd5;
`endif
      if8.out_ready = 8'hDF;
      send8(3'd5, 8'h77);
      @(negedge clk);
      check("pre_rst_held", if8.out_valid, 8'h20);
`ifdef STREAM_DEMUX_CNT_EN
      check("pre_rst_cnt5", cnt_out8, 1);
`endif
      @(posedge clk);
      #1;
      rst = 1'b1;
      sbq.delete();
      cycles(1);
      rst = 1'b0;
      @(negedge clk);
      check("post_rst_out_valid", if8.out_valid, 0);
      check("post_rst_in_ready", if8.in_ready, 1);
      check("post_rst_out_data", if8.out_data, 0);
      @(posedge clk);
      #1;
`ifdef STREAM_DEMUX_CNT_EN
      @(negedge clk);
      check("post_rst_cnt5", cnt_out8, 0);
      @(posedge clk);
      #1;
`endif
      if8.out_ready = 8'hFF;

`ifdef STREAM_DEMUX_CNT_EN
      // Counter wrap on channel 1
      for (int i = 0; i < 65537; i++) begin
         if8.in_valid = 1'b1;
         if8.in_sel   = 3'd1;
         if8.in_data  = i[7:0];
         push_exp(3'd1, i[7:0]);
         @(posedge clk);
         #1;
      end
      if8.in_valid = 1'b0;
      cycles(3);
      cnt_sel8 = 3'd1;
      cycles(2);
      @(negedge clk);
      check("cnt_wrap", cnt_out8, 1);
      @(posedge clk);
      #1;
`endif

      cycles(3);
      check("sb_drained", sbq.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/stream_demux.md
STREAM_DEMUX -- requirements
Module: stream_demux

Interface
REQ-001 The block SHALL have parameter DW, default 8: data width in bits.
REQ-002 The block SHALL have parameter N_CH, default 8: number of output channels, 2..16.
REQ-003 The block SHALL have parameter SW, default 3: select width, with N_CH <= 2**SW.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-006 The block SHALL have port in_valid, input, 1 bit: the upstream word is valid.
REQ-007 The block SHALL have port in_data, input, DW bits: the upstream word.
REQ-008 The block SHALL have port in_sel, input, SW bits: destination channel of the upstream word.
REQ-009 The block SHALL have port in_ready, output, 1 bit: the block accepts the word this cycle.
REQ-010 The block SHALL have port out_valid, output, N_CH bits: one-hot (or zero) valid per channel.
REQ-011 The block SHALL have port out_data, output, DW bits: held word, shared by all channels.
REQ-012 The block SHALL have port out_ready, input, N_CH bits: per-channel downstream ready.
REQ-013 The block SHALL have port drop, output, 1 bit: one-cycle pulse when a word with in_sel >= N_CH is discarded.

Function
REQ-014 The block SHALL treat a transfer in as in_valid && in_ready at a rising clk edge, and a transfer out on channel k as out_valid[k] && out_ready[k].
REQ-015 The block SHALL hold one registered stage: a full flag, a data register and a channel register.
REQ-016 in_ready SHALL be combinationally (!full || out_ready[ch_reg]), so the stage accepts a new word in the same cycle it empties.
REQ-017 On a transfer in with in_sel < N_CH, the block SHALL load data and channel and set full; out_valid[in_sel] SHALL assert the next cycle (latency 1).
REQ-018 out_valid SHALL be zero when the stage is empty, and SHALL have exactly bit ch_reg set when the stage is full.
REQ-019 out_data SHALL equal the data register, and SHALL change only on a load.
REQ-020 When the stage is full and out_ready[ch_reg]=0, the block SHALL hold data, channel and out_valid stable; in_ready SHALL be 0.
REQ-021 The block SHALL ignore out_ready bits of channels other than ch_reg.
REQ-022 On a transfer in with in_sel >= N_CH, the block SHALL discard the word, pulse drop high for the next cycle, and leave the stage contents unaffected except for the emptying described in REQ-023.
REQ-023 When a transfer out and a transfer in occur in the same cycle: a valid-sel transfer in SHALL reload the stage (full stays 1); an invalid-sel transfer in SHALL leave full cleared.
REQ-024 When a transfer out occurs with no transfer in, the block SHALL clear full.
REQ-025 Sustained throughput SHALL be one word per clock when the destination is ready.

Reset
REQ-026 While rst=1 at a clk edge, the block SHALL clear full, the data register, the channel register and drop; out_valid SHALL be 0 the following cycle.
REQ-027 Reset asserted while the stage is full SHALL discard the held word without a transfer out.
REQ-028 in_ready SHALL be 1 in the first cycle after rst deasserts.

Configuration
REQ-029 With STREAM_DEMUX_CNT_EN defined, the block SHALL add input cnt_sel (SW bits), output cnt_out (16 bits), and one 16-bit wrapping counter per channel.
REQ-030 Each counter SHALL increment on every transfer out on its channel, wrap from 0xFFFF to 0, and clear on rst.
REQ-031 cnt_out SHALL be the registered value of counter[cnt_sel], with 1-cycle latency, and SHALL be 0 when cnt_sel >= N_CH.
REQ-032 Without STREAM_DEMUX_CNT_EN, the block SHALL have no counters and no cnt_sel or cnt_out ports, and all other behaviour SHALL be identical.

Verification
REQ-033 Sweep: the bench SHALL drive defaults, all out_ready=1, in_data=0xA5 with in_sel=0..7 on consecutive cycles; each channel k SHALL see out_valid[k] for exactly one cycle carrying 0xA5, with in_ready constantly 1.
REQ-034 Backpressure: the bench SHALL load in_sel=3, in_data=0x5C with out_ready[3]=0 for 4 cycles; out_valid[3] and out_data=0x5C SHALL be stable and in_ready=0; after out_ready[3]=1, exactly one transfer out SHALL occur.
REQ-035 Foreign ready: the bench SHALL hold a word on channel 2 while setting out_ready=8'hFB; the word SHALL not be consumed.
REQ-036 Invalid select: the bench SHALL use N_CH=6 and in_sel=7; drop SHALL pulse for exactly one cycle and out_valid SHALL remain 0.
REQ-037 Reset mid-operation: the bench SHALL assert rst for 1 cycle with a word held on channel 5; out_valid SHALL be 0 next cycle, and with STREAM_DEMUX_CNT_EN the channel 5 counter SHALL read 0.
REQ-038 Counter wrap: with STREAM_DEMUX_CNT_EN, the bench SHALL perform 65537 transfers out on channel 1; cnt_out SHALL read 1 for cnt_sel=1.
